// File: rtl/nn_result_writer.sv
// nn_result_writer
//   Drains the 32-bit result RAM to host memory as 512-bit cache lines.
//   A start pulse samples base_addr/num_words; words are read from the RAM
//   one per cycle, packed 16 to a line (partial last line zero-padded), and
//   each line is written to base_addr + line index. The block then waits for
//   all write acknowledgements before pulsing done.
//
// Optional feature (macro NN_RESULT_FLAG_EN):
//   After the data lines are acknowledged, one status line is written at
//   base_addr + line count with data {zeros, 25'b0, num_words, 64'h1}, and
//   its acknowledgement is awaited before done.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   start           one-cycle launch pulse, honoured only in IDLE
//   base_addr       first destination line address (sampled on start)
//   num_words       words to drain, 0..DEPTH (sampled on start)
//   z_rd_addr       result RAM read address
//   z_dout          result RAM read data, one cycle after z_rd_addr
//   c1_alm_full     host write channel almost full (blocks issue)
//   wr_valid        write request, one cycle per line
//   wr_addr         line address of the request
//   wr_data         line payload
//   wr_rsp_valid    one write acknowledgement per cycle
//   busy            high from the cycle after start until done
//   done            one-cycle completion pulse
//   fsm_state       current FSM state (debug)
//
// Handshake: the write channel has no ready; a request is a single-cycle
// wr_valid pulse launched only when c1_alm_full was low in the cycle before.
// Each request is answered later by exactly one wr_rsp_valid cycle.

module nn_result_writer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 42
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [6:0]        num_words,
    output logic [5:0]        z_rd_addr,
    input  logic [31:0]       z_dout,
    input  logic              c1_alm_full,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [511:0]      wr_data,
    input  logic              wr_rsp_valid,
    output logic              busy,
    output logic              done,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RSP = 3'd3,
`ifdef NN_RESULT_FLAG_EN
        FLAG     = 3'd4,
`endif
        FIN      = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [6:0]        nwords_q;
    logic [6:0]        rd_ptr;      // next word address to present to the RAM
    logic [6:0]        wr_ptr;      // number of words captured so far
    logic [2:0]        line_idx;
    logic              pend;        // a read was presented last cycle
    logic [511:0]      line_buf;
    logic [3:0]        outstanding;
`ifdef NN_RESULT_FLAG_EN
    logic              flag_sent;
    logic [511:0]      flag_line;
    assign flag_line = {416'b0, 25'b0, nwords_q, 64'h1};
`endif

    logic [6:0] words_in;
    logic       read_now;
    logic       last_cap;
    logic       rsp_take;

    assign fsm_state = state;
    assign z_rd_addr = rd_ptr[5:0];
    assign words_in  = (num_words > 7'(DEPTH)) ? 7'(DEPTH) : num_words;

    // Reads stop at the end of the current line so the pipeline is empty
    // when the line is handed to ISSUE.
    assign read_now = (state == FILL) && (rd_ptr < nwords_q) && (rd_ptr[6:4] == line_idx);
    assign last_cap = pend && ((wr_ptr[3:0] == 4'hF) || (wr_ptr + 7'd1 == nwords_q));
    // A response with nothing outstanding is stale (e.g. from before a reset).
    assign rsp_take = wr_rsp_valid && (outstanding != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base_q      <= '0;
            nwords_q    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            line_idx    <= '0;
            pend        <= 1'b0;
            line_buf    <= '0;
            outstanding <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef NN_RESULT_FLAG_EN
            flag_sent   <= 1'b0;
`endif
        end else begin
            wr_valid <= 1'b0;
            done     <= 1'b0;
            pend     <= read_now;
            if (read_now) rd_ptr <= rd_ptr + 7'd1;

            // Counted on the request cycle itself, so a response can never
            // arrive before its own increment.
            case ({wr_valid, rsp_take})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        nwords_q <= words_in;
                        rd_ptr   <= '0;
                        wr_ptr   <= '0;
                        line_idx <= '0;
                        line_buf <= '0;
                        busy     <= 1'b1;
`ifdef NN_RESULT_FLAG_EN
                        flag_sent <= 1'b0;
`endif
                        state    <= (words_in == 7'd0) ? WAIT_RSP : FILL;
                    end
                end
                FILL: begin
                    if (pend) begin
                        line_buf[{wr_ptr[3:0], 5'd0} +: 32] <= z_dout;
                        wr_ptr <= wr_ptr + 7'd1;
                    end
                    if (last_cap) state <= ISSUE;
                end
                ISSUE: begin
                    if (!c1_alm_full) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= base_q + {{(ADDR_W-3){1'b0}}, line_idx};
                        wr_data  <= line_buf;
                        line_buf <= '0;
                        line_idx <= line_idx + 3'd1;
                        state    <= (wr_ptr < nwords_q) ? FILL : WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // wr_valid still high means the last line's increment
                    // has not landed in outstanding yet.
                    if (outstanding == 4'd0 && !wr_valid) begin
`ifdef NN_RESULT_FLAG_EN
                        state <= FLAG;
`else
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`endif
                    end
                end
`ifdef NN_RESULT_FLAG_EN
                FLAG: begin
                    if (!flag_sent) begin
                        if (!c1_alm_full) begin
                            wr_valid  <= 1'b1;
                            wr_addr   <= base_q + {{(ADDR_W-3){1'b0}}, line_idx};
                            wr_data   <= flag_line;
                            flag_sent <= 1'b1;
                        end
                    end else if (outstanding == 4'd0 && !wr_valid) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
